// File: rtl/ser_arbiter.sv
// Round-robin scheduler sharing one MSB-first serializer among NREQ producers.
// Loads the granted word with a one-cycle strobe, counts bits, then holds a guard gap.
module ser_arbiter #(
  parameter int L       = 8,
  parameter int NREQ    = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*L-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [L-1:0]            q,
  output logic                    qstrobe,
  input  logic                    qbiten,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [31:0]             words_sent,
  output logic                    err
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(L + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] GLAST = 8'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic          found;
  logic [L-1:0]  word;
  logic [BW-1:0] bitcnt;
  logic [WW-1:0] wd;
  logic [7:0]    gcnt;
  logic          end_word;
  logic          timeout;
  int            j;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < NREQ; k++)
      if (pick == IW'(k))
        word = req_data[k*L +: L];
  end

  assign req_ready = (state == S_IDLE && found)
                   ? (NREQ'(1) << pick) : '0;
  assign busy      = (state != S_IDLE);

  assign end_word = (state == S_SHIFT) && qbiten
                 && (bitcnt == BW'(L - 1));
  assign timeout  = (state == S_SHIFT) && !qbiten
                 && (wd == WW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (found) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT:
        if (end_word || timeout)
          state_nx = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gcnt == GLAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      q          <= '0;
      qstrobe    <= 1'b0;
      grant_id   <= '0;
      words_sent <= '0;
      err        <= 1'b0;
      ptr        <= '0;
      bitcnt     <= '0;
      wd         <= '0;
      gcnt       <= '0;
    end else begin
      state   <= state_nx;
      qstrobe <= 1'b0;
      unique case (state)
        S_IDLE:
          if (found) begin
            q        <= word;
            grant_id <= pick;
            qstrobe  <= 1'b1;
            ptr      <= (pick == IW'(NREQ - 1))
                      ? '0 : pick + IW'(1);
          end
        S_LOAD: begin
          bitcnt <= '0;
          wd     <= '0;
        end
        S_SHIFT: begin
          gcnt <= '0;
          if (qbiten) begin
            bitcnt <= bitcnt + BW'(1);
            wd     <= '0;
          end else begin
            wd <= wd + WW'(1);
          end
          if (end_word) words_sent <= words_sent + 32'd1;
          if (timeout)  err <= 1'b1;
        end
        S_GAP:   gcnt <= gcnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_arbiter.sv
// Bench for ser_arbiter: transaction model + directed scenarios,
// with a second GAP=0 instance for back-to-back timing.
module tb_ser_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  q;
  logic        qstrobe;
  logic        qbiten;
  logic [1:0]  grant_id;
  logic        busy;
  logic [31:0] words_sent;
  logic        err;

  logic        rst_b;
  logic [3:0]  ready_b;
  logic [7:0]  q_b;
  logic        qs_b;
  logic        qbiten_b;
  logic [1:0]  gid_b;
  logic        busy_b;
  logic [31:0] ws_b;
  logic        err_b;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ser_arbiter #(.L(8), .NREQ(4), .GAP(1), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .q(q),
    .qstrobe(qstrobe), .qbiten(qbiten), .grant_id(grant_id),
    .busy(busy), .words_sent(words_sent), .err(err)
  );

  ser_arbiter #(.L(8), .NREQ(4), .GAP(0), .TIMEOUT(64)) dut_b (
    .clk(clk), .reset(rst_b), .req_valid(4'b0010),
    .req_data(32'h0000_5A00), .req_ready(ready_b), .q(q_b),
    .qstrobe(qs_b), .qbiten(qbiten_b), .grant_id(gid_b),
    .busy(busy_b), .words_sent(ws_b), .err(err_b)
  );

  // serializer stubs: load on strobe, then stub_limit bits MSB-first
  logic [7:0] sr;
  logic [3:0] scnt, scnt_b;
  logic [3:0] stub_limit;
  logic       qbit;

  always @(posedge clk) begin
    if (reset) scnt <= '0;
    else if (qstrobe) begin sr <= q; scnt <= stub_limit; end
    else if (scnt != 0) begin sr <= sr << 1; scnt <= scnt - 4'd1; end
  end
  assign qbiten = (scnt != 0);
  assign qbit   = sr[7];

  always @(posedge clk) begin
    if (rst_b) scnt_b <= '0;
    else if (qs_b) scnt_b <= 4'd8;
    else if (scnt_b != 0) scnt_b <= scnt_b - 4'd1;
  end
  assign qbiten_b = (scnt_b != 0);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic int rr(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // transaction-level model of the GAP=1 instance
  localparam int MGAP = 1;
  bit m_ok = 1'b0;
  int m_ptr, m_q, m_gid, m_ws, m_bits, m_quiet, m_gapleft;
  bit m_err, m_strobe, m_busy, m_load;

  function automatic void m_finish();
    m_bits    = -1;
    m_gapleft = MGAP;
    if (MGAP == 0) m_busy = 1'b0;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [3:0] er;
    w  = rr(req_valid, m_ptr);
    er = (!m_busy && w >= 0) ? 4'(1 << w) : 4'd0;
    if (m_ok) begin
      check("m_ready", 32'(req_ready), 32'(er));
      check("m_q", 32'(q), 32'(m_q));
      check("m_strobe", 32'(qstrobe), 32'(m_strobe));
      check("m_gid", 32'(grant_id), 32'(m_gid));
      check("m_busy", 32'(busy), 32'(m_busy));
      check("m_words", words_sent, 32'(m_ws));
      check("m_err", 32'(err), 32'(m_err));
    end
    if (reset) begin
      m_ok = 1'b1; m_ptr = 0; m_q = 0; m_gid = 0; m_ws = 0;
      m_err = 0; m_strobe = 0; m_busy = 0; m_load = 0;
      m_bits = -1; m_quiet = 0; m_gapleft = 0;
    end else if (m_ok) begin
      m_strobe = 1'b0;
      if (!m_busy) begin
        if (w >= 0) begin
          m_q = int'(req_data[w*8 +: 8]);
          m_gid = w; m_ptr = (w + 1) % 4;
          m_busy = 1'b1; m_load = 1'b1; m_strobe = 1'b1;
        end
      end else if (m_load) begin
        m_load = 1'b0; m_bits = 0; m_quiet = 0;
      end else if (m_bits >= 0) begin
        if (qbiten) begin m_bits++; m_quiet = 0; end
        else m_quiet++;
        if (m_bits == 8) begin m_ws++; m_finish(); end
        else if (m_quiet == 64) begin m_err = 1'b1; m_finish(); end
      end else begin
        m_gapleft--;
        if (m_gapleft == 0) m_busy = 1'b0;
      end
    end
  end

  // back-to-back instance: strobe period and ready-while-busy
  int last_b = -1;
  int nper = 0;
  always @(negedge clk) begin
    if (!rst_b) begin
      if (qs_b) begin
        if (last_b >= 0 && nper < 5) begin
          check("b2b_period", 32'(cyc - last_b), 32'd10);
          nper++;
        end
        last_b = cyc;
      end
      if (busy_b) check("b2b_ready_busy", 32'(ready_b), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(output logic [3:0] r);
    bit got = 1'b0;
    r = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin r = req_ready; got = 1'b1; end
    end
    if (!got) check("hs_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    if (!got) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [7:0] bits;
    int nb, hs, ns, last, errc;
    logic [1:0] gseq [8];
    logic [7:0] qseq [8];

    reset = 1'b1; rst_b = 1'b1;
    req_valid = '0; req_data = '0; stub_limit = 4'd8;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; rst_b = 1'b0;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", words_sent, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_strobe", 32'(qstrobe), 32'd0);

    // single word from requester 2
    step();
    req_data[16 +: 8] = 8'b0110_1001;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h4);
    step(); req_valid = '0;
    @(negedge clk);
    check("single_strobe", 32'(qstrobe), 32'd1);
    bits = '0; nb = 0;
    for (int i = 0; i < 40 && nb < 8; i++) begin
      @(negedge clk);
      if (qbiten) begin bits = {bits[6:0], qbit}; nb++; end
    end
    check("single_nbits", 32'(nb), 32'd8);
    check("single_bits", 32'(bits), 32'h69);
    check("single_gid", 32'(grant_id), 32'd2);
    @(negedge clk);
    check("single_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_words", words_sent, 32'd1);

    // round robin from a fresh pointer
    step(); pulse_reset();
    req_data = 32'hA3A2_A1A0; req_valid = 4'hF;
    hs = 0; ns = 0;
    for (int i = 0; i < 300 && !(hs == 6 && !busy); i++) begin
      @(negedge clk);
      if (qstrobe && ns < 8) begin
        gseq[ns] = grant_id; qseq[ns] = q; ns++;
      end
      if (req_ready != 0) hs++;
      step();
      if (hs == 6) req_valid = '0;
    end
    check("rr_nwords", 32'(ns), 32'd6);
    for (int k = 0; k < 6 && k < ns; k++) begin
      check("rr_gid", 32'(gseq[k]), 32'(k % 4));
      check("rr_q", 32'(qseq[k]), 32'(8'hA0 + k % 4));
    end
    @(negedge clk);
    check("rr_words", words_sent, 32'd6);

    // watchdog: serializer stalls after 3 bits
    step();
    stub_limit = 4'd3;
    req_data[8 +: 8] = 8'h3C; req_valid = 4'b0010;
    wait_hs(r); req_valid = '0;
    check("wd_grant", 32'(r), 32'h2);
    last = -1; errc = -1;
    for (int i = 0; i < 200 && errc < 0; i++) begin
      @(negedge clk);
      if (qbiten) last = cyc;
      if (err) errc = cyc;
    end
    check("wd_quiet_cycles", 32'(errc - last - 1), 32'd64);
    wait_idle();
    check("wd_words", words_sent, 32'd6);
    stub_limit = 4'd8;
    step();
    req_data[8 +: 8] = 8'hC3; req_valid = 4'b0010;
    wait_hs(r); req_valid = '0;
    for (int i = 0; i < 40 && words_sent != 32'd7; i++)
      @(negedge clk);
    check("wd_next_words", words_sent, 32'd7);
    check("wd_err_sticky", 32'(err), 32'd1);
    wait_idle();

    // reset after the 4th bit of a word
    step();
    req_data[16 +: 8] = 8'h96; req_valid = 4'b0100;
    wait_hs(r); req_valid = '0;
    nb = 0;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      @(negedge clk);
      if (qbiten) nb++;
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_words", words_sent, 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_q", 32'(q), 32'd0);
    check("mid_gid", 32'(grant_id), 32'd0);
    check("mid_ready", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    wait_idle();
    check("mid_after_gid", 32'(grant_id), 32'd0);
    check("mid_after_words", words_sent, 32'd1);

    // sparse requests and pointer wrap
    step();
    req_valid = 4'b1000;
    wait_hs(r);
    check("sparse_3", 32'(r), 32'h8);
    req_valid = 4'b1001;
    wait_hs(r);
    check("sparse_0", 32'(r), 32'h1);
    wait_hs(r);
    check("sparse_3_again", 32'(r), 32'h8);
    req_valid = '0;
    wait_idle();
    check("b2b_periods_seen", 32'(nper), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ser_arbiter.md
Name: ser_arbiter

Overview:
- Round-robin scheduler that shares one `serializer` (L-bit word in, MSB-first bit stream out) between NREQ word producers, e.g. several Toeplitz extractor lanes.
- Accepts words over valid/ready handshakes and loads the granted word into the serializer with a single-cycle `qstrobe`.
- Counts the serializer's `qbiten` cycles to detect end of word, then enforces a guard gap before the next load.
- Reports the source tag, a sent-word count and a stall watchdog error.

Parameters:
- L, 8: word width, identical to the serializer's L.
- NREQ, 4: number of requesters, 2..16.
- GAP, 1: idle cycles inserted after each word completes, 0..255.
- TIMEOUT, 64: maximum cycles without a `qbiten` pulse while shifting before abort; must be > L.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*L  requester i word at bits [i*L +: L].
- req_ready  out  NREQ  one-hot accept; transfer occurs when `req_valid[i] & req_ready[i]` at posedge.
- q  out  L  word to serializer.
- qstrobe  out  1  one-cycle load pulse to serializer.
- qbiten  in  1  serializer bit-valid, high once per emitted bit.
- grant_id  out  $clog2(NREQ)  source index of the word currently or last serialized.
- busy  out  1  high in LOAD, SHIFT and GAP states.
- words_sent  out  32  count of fully serialized words, wraps modulo 2^32.
- err  out  1  sticky watchdog flag, cleared only by reset.

Behaviour:
- Reset (sync, any state, including mid-word):
  - state=IDLE, `q`=0, `qstrobe`=0, `req_ready`=0, `grant_id`=0, `busy`=0, `words_sent`=0, `err`=0.
  - Priority pointer ptr=0 and bit counter=0.
  - An in-flight word is dropped; it is neither counted nor re-served.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - `req_ready` is combinational: one-hot on the first valid index found scanning ptr, ptr+1, ... modulo NREQ; zero if no `req_valid`.
  - `req_ready` is never asserted outside IDLE and never to a non-valid requester.
  - On handshake: `q`<=`req_data[w]`, `grant_id`<=w, ptr<=(w+1) mod NREQ, state->LOAD.
- LOAD (exactly 1 cycle):
  - `qstrobe`=1 (registered, so it rises the cycle after the handshake).
  - bitcnt<=0, watchdog<=0, state->SHIFT.
- SHIFT:
  - `q` holds stable.
  - Each cycle with `qbiten`=1: bitcnt++ and watchdog<=0; otherwise watchdog++.
  - When bitcnt reaches L (the L-th `qbiten` cycle): `words_sent`++, state->GAP, or ->IDLE if GAP=0.
  - If watchdog reaches TIMEOUT: `err`<=1, state->IDLE (or GAP); `words_sent` not incremented.
  - `qbiten` beyond the L-th bit in SHIFT is impossible by construction. `qbiten` in IDLE or GAP is ignored.
- GAP: count GAP cycles, then ->IDLE.
- Throughput: GAP=0 with a serializer emitting bits on consecutive cycles gives handshake-to-handshake period of L+2 cycles (IDLE, LOAD, L×SHIFT).
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,...
- A requester dropping `req_valid` while not granted loses no state.
- `qstrobe` is never high in two consecutive cycles.

Test Plan:
- Single word: L=8, NREQ=4, GAP=1, requester 2 presents 8'b01101001 with real serializer. Required:
  - handshake in 1 cycle;
  - `qstrobe` high exactly 1 cycle later;
  - `qbit` sequence 0,1,1,0,1,0,0,1 MSB-first over 8 `qbiten` cycles;
  - `grant_id`=2, `words_sent`=1;
  - `busy` low 1 cycle after the last bit.
- Round robin: all 4 requesters valid continuously, each with distinct data 8'hA0+i. Required: grant order 0,1,2,3,0,1; each `q` matches its source; `words_sent`=6 after six words.
- Back-to-back timing: GAP=0, one requester always valid. Required: `qstrobe` pulses exactly 10 cycles apart; `req_ready` never high during SHIFT.
- Watchdog: stub serializer emits 3 `qbiten` then stops, TIMEOUT=64. Required: `err`=1 exactly 64 cycles after the last pulse; block returns to IDLE; next word serializes normally; `err` stays 1; `words_sent` unchanged by the aborted word.
- Reset mid-word: assert `reset` for 1 cycle after the 4th bit. Required: next cycle all outputs at reset values, ptr=0 so requester 0 is served first, `words_sent`=0.
- Sparse/priority: only requester 3 valid, then requesters 0 and 3 valid together. Required: 3 granted, then 0 granted (ptr wrapped to 0), then 3.
